hilo_div_writer: RTL and testbench

- Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
- Produces the 64-bit {HI=remainder, LO=quotient} word and the write-enable strobe that feeds the HI/LO register write port.
- Stalls the pipeline while dividing.
- Supports squash on a pipeline flush.

---
 rtl/hilo_div_writer.sv | 145 ++++++++++++++
 tb/tb_hilo_div_writer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/hilo_div_writer.sv
// hilo_div_writer
//   Iterative radix-2 restoring divider for DIV/DIVU in EX. Produces the
//   {HI=remainder, LO=quotient} word and the HI/LO write strobe. It holds the
//   pipeline while dividing, and a flush of the EX instruction squashes it.
//
//   Optional build macro: DIV_ZERO_FAST_EN. When it is defined, a divide by
//   zero skips the iterations and finishes one cycle after acceptance.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start_i           DIV/DIVU in EX, held by the pipeline until result_valid_o
//   signed_i          1=DIV, 0=DIVU (sampled with start_i)
//   annul_i           flush of the EX instruction (synchronous abort)
//   a_i, b_i          dividend / divisor (sampled with start_i)
//   stall_o           pipeline hold request (combinational)
//   busy_o            divider not idle (registered)
//   result_valid_o    one-cycle pulse, result_o valid
//   hilo_we_o         HI/LO write strobe, equals result_valid_o
//   result_o          {remainder, quotient}
module hilo_div_writer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               signed_i,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               stall_o,
    output logic               busy_o,
    output logic               result_valid_o,
    output logic               hilo_we_o,
    output logic [2*WIDTH-1:0] result_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   rem;     // partial remainder
    logic [WIDTH-1:0]   dq;      // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0]   dvs;     // divisor magnitude
    logic               qneg, rneg;
    logic [CNT_W-1:0]   cnt;

    logic               accept, last;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     trial;
    logic               qbit;
    logic [WIDTH-1:0]   rem_nxt, dq_nxt, rem_fin, quo_fin;

    assign accept = (state == IDLE) && start_i && !annul_i;
    assign last   = (state == CALC) && (cnt == CNT_W'(WIDTH-1));

    assign a_mag  = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag  = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

    // rem < dvs always holds, so bit WIDTH of the trial difference is a clean
    // borrow flag. With dvs==0 every trial succeeds: quotient all-ones,
    // remainder |a|, which after sign fix-up is the divide-by-zero result.
    assign trial   = {rem, dq[WIDTH-1]} - {1'b0, dvs};
    assign qbit    = !trial[WIDTH];
    assign rem_nxt = qbit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dq[WIDTH-1]};
    assign dq_nxt  = {dq[WIDTH-2:0], qbit};
    assign rem_fin = rneg ? -rem_nxt : rem_nxt;
    assign quo_fin = qneg ? -dq_nxt  : dq_nxt;

`ifdef DIV_ZERO_FAST_EN
    logic               b_zero;
    logic [2*WIDTH-1:0] zres;
    assign b_zero = (b_i == '0);
    assign zres   = {a_i, (signed_i && a_i[WIDTH-1]) ? WIDTH'(1) : {WIDTH{1'b1}}};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rem      <= '0;
            dq       <= '0;
            dvs      <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            result_o <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem  <= '0;
                        dq   <= a_mag;
                        dvs  <= b_mag;
                        qneg <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        rneg <= signed_i && a_i[WIDTH-1];
                        cnt  <= '0;
`ifdef DIV_ZERO_FAST_EN
                        if (b_zero) result_o <= zres;
`endif
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    dq  <= dq_nxt;
                    cnt <= cnt + CNT_W'(1);
                    // result_o only changes when a DONE will follow
                    if (last && !annul_i) result_o <= {rem_fin, quo_fin};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt      = state;
        stall_o        = 1'b0;
        busy_o         = (state != IDLE);
        result_valid_o = 1'b0;
        case (state)
            IDLE: begin
                stall_o = accept;
                if (accept) begin
`ifdef DIV_ZERO_FAST_EN
                    state_nxt = b_zero ? DONE : CALC;
`else
                    state_nxt = CALC;
`endif
                end
            end
            CALC: begin
                stall_o = 1'b1;
                if (annul_i)   state_nxt = IDLE;
                else if (last) state_nxt = DONE;
            end
            DONE: begin
                result_valid_o = !annul_i;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign hilo_we_o = result_valid_o;

endmodule

// File: tb/tb_hilo_div_writer.sv
module tb_hilo_div_writer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst, start_i, signed_i, annul_i;
    logic [W-1:0]  a_i, b_i;
    logic          stall_o, busy_o, result_valid_o, hilo_we_o;
    logic [2*W-1:0] result_o;

    int n_chk = 0, n_pass = 0;
    int done_ops = 0, we_cnt = 0;

    hilo_div_writer #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i),
        .annul_i(annul_i), .a_i(a_i), .b_i(b_i), .stall_o(stall_o),
        .busy_o(busy_o), .result_valid_o(result_valid_o),
        .hilo_we_o(hilo_we_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (hilo_we_o) we_cnt <= we_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: plain integer division, truncating toward zero (C semantics)
    function automatic logic [63:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s);
        longint sa, sb, q, r;
        if (b == 0) return {a, (s && a[W-1]) ? 32'd1 : 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called just after a rising edge; that cycle is cycle 0 (the acceptance cycle).
    // Operands are scrambled every cycle after acceptance.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input bit keep);
        logic [63:0] exp;
        int          lat, exp_lat;
        bit          got, stall_ok;
        exp      = ref_div(a, b, s);
        exp_lat  = W + 1;
`ifdef DIV_ZERO_FAST_EN
        if (b == 0) exp_lat = 1;
`endif
        start_i  = 1'b1; a_i = a; b_i = b; signed_i = s;
        got      = 0; stall_ok = 1; lat = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 0) chk("busy_at_start", {63'd0, busy_o}, 64'd0);
            if (result_valid_o) begin got = 1; lat = c; break; end
            if (!stall_o) stall_ok = 0;
            @(posedge clk); #1;
            a_i = $urandom; b_i = $urandom; signed_i = 1'($urandom);
        end
        chk("valid_seen", {63'd0, got}, 64'd1);
        if (got) begin
            done_ops++;
            chk("latency", 64'(lat), 64'(exp_lat));
            chk("stall_while_busy", {63'd0, stall_ok}, 64'd1);
            chk("stall_in_done", {63'd0, stall_o}, 64'd0);
            chk("we_eq_valid", {63'd0, hilo_we_o}, 64'd1);
            chk("result", result_o, exp);
        end
        @(posedge clk); #1;
        if (!keep) start_i = 1'b0;
    endtask

    task automatic abort_op(input bit use_rst);
        start_i = 1'b1; a_i = 32'd1000; b_i = 32'd3; signed_i = 1'b0;
        for (int c = 0; c < 10; c++) begin @(posedge clk); #1; end
        if (use_rst) rst = 1'b1; else annul_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; annul_i = 1'b0;
        chk(use_rst ? "busy_after_rst" : "busy_after_annul", {63'd0, busy_o}, 64'd0);
        if (use_rst) chk("result_after_rst", result_o, 64'd0);
        do_div(32'd9, 32'd3, 1'b0, 0);
    endtask

    initial begin
        rst = 1'b1; start_i = 0; signed_i = 0; annul_i = 0; a_i = 0; b_i = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",  {63'd0, busy_o},         64'd0);
        chk("rst_valid", {63'd0, result_valid_o}, 64'd0);
        chk("rst_we",    {63'd0, hilo_we_o},      64'd0);
        chk("rst_stall", {63'd0, stall_o},        64'd0);
        chk("rst_result", result_o,               64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_div(32'd100,        32'd7,          1'b0, 0);
        do_div(32'hFFFF_FFF9,  32'd2,          1'b1, 0);
        do_div(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 0);
        do_div(32'd5,          32'd0,          1'b0, 0);
        do_div(32'hFFFF_FFFB,  32'd0,          1'b1, 0);

        abort_op(0);
        abort_op(1);

        // back-to-back with start held through DONE
        do_div(32'd12345,      32'd11,         1'b0, 1);
        do_div(32'hDEAD_BEEF,  32'd77,         1'b0, 0);

        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(1, 15));
                1: b = 32'd0;
                2: b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            do_div(a, b, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                start_i = 1'b0;
                @(posedge clk); #1;
            end
        end

        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("we_count", 64'(we_cnt), 64'(done_ops));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
